pipeline_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). Drives the stall and

---
 rtl/pipeline_ctrl_pkg.sv | 34 +++
 rtl/pipeline_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/sequencing controller.
// Operand-forwarding selection is only used when PIPE_CTRL_FWD_EN is defined.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    PC_RUN      = 1'b0,
    PC_REDIRECT = 1'b1
  } pipe_ctrl_state_t;

  // Wide enough for REDIRECT_BUBBLES-1 with REDIRECT_BUBBLES up to 7.
  localparam int BUB_W = 3;

  // A producer writing x0 never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] rs, input logic rs_used);
    return we && rs_used && (rd == rs) && (rd != 5'd0);
  endfunction

  // The younger producer (EX/MEM) wins over MEM/WB.
  function automatic fwd_sel_t fwd_select(input logic [4:0] mem_rd, input logic mem_we,
                                          input logic [4:0] wb_rd, input logic wb_we,
                                          input logic [4:0] rs, input logic rs_used);
    if (reg_match(mem_rd, mem_we, rs, rs_used)) return FWD_EX_MEM;
    if (reg_match(wb_rd, wb_we, rs, rs_used))   return FWD_MEM_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: RAW/load-use stalls, redirect squash,
// optional operand forwarding (define PIPE_CTRL_FWD_EN) and saturating perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_write_rd_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       mem_rd_addr_i,
  input  logic             mem_write_rd_i,
  input  logic [4:0]       wb_rd_addr_i,
  input  logic             wb_write_rd_i,
  input  logic             load_pc_i,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       fwd_rs1_sel_o,
  output logic [1:0]       fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(REDIRECT_BUBBLES - 1);

  pipe_ctrl_state_t state, state_nxt;
  logic [BUB_W-1:0] bub_cnt, bub_nxt;
  logic             redirect;
  logic             hazard;
  logic             stall_req;

  logic ex_hit, mem_hit, wb_hit;
  assign ex_hit  = reg_match(ex_rd_addr_i, ex_write_rd_i, id_rs1_addr_i, id_uses_rs1_i)
                 | reg_match(ex_rd_addr_i, ex_write_rd_i, id_rs2_addr_i, id_uses_rs2_i);
  assign mem_hit = reg_match(mem_rd_addr_i, mem_write_rd_i, id_rs1_addr_i, id_uses_rs1_i)
                 | reg_match(mem_rd_addr_i, mem_write_rd_i, id_rs2_addr_i, id_uses_rs2_i);
  assign wb_hit  = reg_match(wb_rd_addr_i, wb_write_rd_i, id_rs1_addr_i, id_uses_rs1_i)
                 | reg_match(wb_rd_addr_i, wb_write_rd_i, id_rs2_addr_i, id_uses_rs2_i);

`ifdef PIPE_CTRL_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = ex_is_load_i & ex_hit;
  assign fwd_rs1_sel_o = rstn_i ? fwd_select(mem_rd_addr_i, mem_write_rd_i, wb_rd_addr_i,
                                             wb_write_rd_i, id_rs1_addr_i, id_uses_rs1_i)
                                : FWD_RF;
  assign fwd_rs2_sel_o = rstn_i ? fwd_select(mem_rd_addr_i, mem_write_rd_i, wb_rd_addr_i,
                                             wb_write_rd_i, id_rs2_addr_i, id_uses_rs2_i)
                                : FWD_RF;
`else
  // No RF write-through: the consumer waits until the producer has left WB.
  assign hazard = ex_hit | mem_hit | wb_hit;
  assign fwd_rs1_sel_o = FWD_RF;
  assign fwd_rs2_sel_o = FWD_RF;
  logic unused_load_flag;
  assign unused_load_flag = ex_is_load_i;
`endif

  // NOTE: reset is synchronous, so it is sampled only at the clock edge inside the branch.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state   <= PC_RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  // NOTE: defaults first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    bub_nxt   = bub_cnt;
    if (load_pc_i) begin
      if (REDIRECT_BUBBLES > 1) begin
        state_nxt = PC_REDIRECT;
        bub_nxt   = BUB_RELOAD;
      end else begin
        state_nxt = PC_RUN;
      end
    end else if (state == PC_REDIRECT) begin
      if (bub_cnt == BUB_W'(1)) state_nxt = PC_RUN;
      bub_nxt = bub_cnt - BUB_W'(1);
    end
  end

  // Redirect outranks any data hazard: the stalled ID instruction is wrong-path anyway.
  assign redirect  = load_pc_i | (state == PC_REDIRECT);
  assign stall_req = hazard & ~redirect;

  assign if_id_stall_o  = rstn_i & stall_req;
  assign if_id_flush_o  = rstn_i & redirect;
  assign id_ex_stall_o  = 1'b0;
  assign id_ex_flush_o  = rstn_i & (load_pc_i | stall_req);
  assign ex_mem_flush_o = 1'b0;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .inc_i   (if_id_stall_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .inc_i   (if_id_flush_o),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic against
// a cycle-level reference model; follows PIPE_CTRL_FWD_EN when it is defined.
module tb_pipeline_ctrl;

  localparam int RB    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic use1, use2, ex_we, ex_load, mem_we, wb_we, load_pc;
  logic if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [1:0] fwd1, fwd2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: remaining IF/ID flush cycles after the current one, and counts.
  int flush_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_ctrl #(.REDIRECT_BUBBLES(RB), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
    .ex_rd_addr_i(ex_rd), .ex_write_rd_i(ex_we), .ex_is_load_i(ex_load),
    .mem_rd_addr_i(mem_rd), .mem_write_rd_i(mem_we),
    .wb_rd_addr_i(wb_rd), .wb_write_rd_i(wb_we),
    .load_pc_i(load_pc),
    .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
    .ex_mem_flush_o(ex_mem_flush),
    .fwd_rs1_sel_o(fwd1), .fwd_rs2_sel_o(fwd2),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit dep(input logic [4:0] rd, input logic we,
                             input logic [4:0] rs, input logic used);
    return (we === 1'b1) && (used === 1'b1) && (rd == rs) && (rs != 0);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs, input logic used);
`ifdef PIPE_CTRL_FWD_EN
    if (dep(mem_rd, mem_we, rs, used)) return 2'd1;
    if (dep(wb_rd, wb_we, rs, used))   return 2'd2;
`endif
    return 2'd0;
  endfunction

  // Expected {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, fwd1, fwd2}.
  function automatic logic [8:0] model_out();
    bit redir, haz, stl;
    if (!rstn) return 9'd0;
    redir = load_pc || (flush_left > 0);
`ifdef PIPE_CTRL_FWD_EN
    haz = ex_load && (dep(ex_rd, ex_we, id_rs1, use1) || dep(ex_rd, ex_we, id_rs2, use2));
`else
    haz = dep(ex_rd, ex_we, id_rs1, use1) || dep(ex_rd, ex_we, id_rs2, use2)
       || dep(mem_rd, mem_we, id_rs1, use1) || dep(mem_rd, mem_we, id_rs2, use2)
       || dep(wb_rd, wb_we, id_rs1, use1) || dep(wb_rd, wb_we, id_rs2, use2);
`endif
    stl = haz && !redir;
    return {stl, redir, 1'b0, (load_pc || stl), 1'b0, m_fwd(id_rs1, use1), m_fwd(id_rs2, use2)};
  endfunction

  function automatic logic [8:0] observed();
    return {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush, fwd1, fwd2};
  endfunction

  // Advance one clock and let the model follow the rules for that cycle.
  task automatic tick();
    logic [8:0] e;
    e = model_out();
    @(posedge clk);
    if (!rstn) begin
      flush_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e[8] && m_stall < CMAX) m_stall++;
      if (e[7] && m_flush < CMAX) m_flush++;
      if (load_pc)             flush_left = RB - 1;
      else if (flush_left > 0) flush_left--;
    end
    #2;
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; use1 = 0; use2 = 0;
    ex_rd = 0; ex_we = 0; ex_load = 0;
    mem_rd = 0; mem_we = 0; wb_rd = 0; wb_we = 0; load_pc = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    load_pc = 1'b1;
    id_rs1 = 5; use1 = 1; ex_rd = 5; ex_we = 1; ex_load = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (observed() !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, observed(), 9'd0);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    rstn = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (observed() !== 9'd0) begin
      errors++;
      $display("FAIL reset_release_run: got %b expected %b", observed(), 9'd0);
    end
    tick();
  endtask

  // Drives a producer walking EX -> MEM -> WB -> gone while the consumer sits in ID.
  task automatic run_producer(input string name, input logic [4:0] rd, input bit is_load,
                              input bit on_rs2, input int exp_stalls);
    do_reset();
    if (on_rs2) begin id_rs2 = rd; use2 = 1; end
    else        begin id_rs1 = rd; use1 = 1; end
    for (int c = 0; c < 4; c++) begin
      ex_rd = rd;  ex_we  = (c == 0); ex_load = (c == 0) && is_load;
      mem_rd = rd; mem_we = (c == 1);
      wb_rd = rd;  wb_we  = (c == 2);
      #1;
      checks++;
      if (observed() !== model_out()) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, observed(), model_out());
      end
`ifdef PIPE_CTRL_FWD_EN
      if (c == 1 || c == 2) begin
        checks++;
        if ((on_rs2 ? fwd2 : fwd1) !== ((c == 1) ? 2'd1 : 2'd2)) begin
          errors++;
          $display("FAIL %s_fwd cycle %0d: got %0d expected %0d", name, c,
                   on_rs2 ? fwd2 : fwd1, (c == 1) ? 1 : 2);
        end
      end
`endif
      tick();
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_stalls)) begin
      errors++;
      $display("FAIL %s_stall_cnt: got %0d expected %0d", name, stall_cnt, exp_stalls);
    end
  endtask

  task automatic test_load_use();
`ifdef PIPE_CTRL_FWD_EN
    run_producer("load_use", 5'd5, 1'b1, 1'b0, 1);
`else
    run_producer("load_use", 5'd5, 1'b1, 1'b0, 3);
`endif
  endtask

  task automatic test_raw();
`ifdef PIPE_CTRL_FWD_EN
    run_producer("raw_alu", 5'd7, 1'b0, 1'b1, 0);
`else
    run_producer("raw_alu", 5'd7, 1'b0, 1'b1, 3);
`endif
  endtask

  task automatic test_x0();
    do_reset();
    id_rs1 = 0; use1 = 1; id_rs2 = 0; use2 = 1;
    ex_rd = 0; ex_we = 1; ex_load = 1; mem_rd = 0; mem_we = 1; wb_rd = 0; wb_we = 1;
    #1;
    checks++;
    if (observed() !== 9'd0) begin
      errors++;
      $display("FAIL x0_no_hazard: got %b expected %b", observed(), 9'd0);
    end
    tick();
  endtask

  task automatic test_redirect();
    int n_if, n_idex;
    do_reset();
    n_if = 0; n_idex = 0;
    for (int c = 0; c < 5; c++) begin
      load_pc = (c == 0);
      #1;
      checks++;
      if (observed() !== model_out()) begin
        errors++;
        $display("FAIL redirect cycle %0d: got %b expected %b", c, observed(), model_out());
      end
      n_if += int'(if_id_flush);
      n_idex += int'(id_ex_flush);
      tick();
    end
    checks++;
    if (n_if != RB || n_idex != 1 || flush_cnt !== CNT_W'(RB)) begin
      errors++;
      $display("FAIL redirect_counts: got if_id=%0d id_ex=%0d flush_cnt=%0d expected %0d/1/%0d",
               n_if, n_idex, flush_cnt, RB, RB);
    end
    // Redirect concurrent with a load-use: redirect wins, no stall.
    ex_rd = 5; ex_we = 1; ex_load = 1; id_rs1 = 5; use1 = 1; load_pc = 1;
    #1;
    checks++;
    if (if_id_stall !== 1'b0 || if_id_flush !== 1'b1 || id_ex_flush !== 1'b1) begin
      errors++;
      $display("FAIL redirect_vs_hazard: got stall=%b if_flush=%b idex_flush=%b expected 0/1/1",
               if_id_stall, if_id_flush, id_ex_flush);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int n_if;
    do_reset();
    n_if = 0;
    for (int c = 0; c < 6; c++) begin
      load_pc = (c < 2);
      #1;
      checks++;
      if (observed() !== model_out()) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, observed(), model_out());
      end
      n_if += int'(if_id_flush);
      tick();
    end
    checks++;
    if (n_if != RB + 1) begin
      errors++;
      $display("FAIL back_to_back_total: got %0d expected %0d", n_if, RB + 1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_rd = 3; ex_we = 1; ex_load = 1; id_rs1 = 3; use1 = 1;
    for (int c = 0; c < 20; c++) tick();
    clear_inputs();
    for (int c = 0; c < 20; c++) begin
      load_pc = 1;
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if (stall_cnt !== CNT_W'(CMAX) || flush_cnt !== CNT_W'(CMAX)) begin
      errors++;
      $display("FAIL saturation: got stall=%0d flush=%0d expected %0d/%0d",
               stall_cnt, flush_cnt, CMAX, CMAX);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom);
      ex_rd = 5'($urandom_range(0, 3)); ex_we = 1'($urandom); ex_load = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_we = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_we = 1'($urandom);
      load_pc = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (observed() !== model_out() || stall_cnt !== CNT_W'(m_stall) ||
          flush_cnt !== CNT_W'(m_flush)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b s=%0d f=%0d expected %b s=%0d f=%0d", c,
                 observed(), stall_cnt, flush_cnt, model_out(), m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b0;
    @(posedge clk);
    #2;
    test_reset();
    test_load_use();
    test_raw();
    test_x0();
    test_redirect();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
